// File: rtl/matrix_memory_pkg.sv
// Shared types for the playfield matrix: tile origin point and the lock/line-clear FSM states.
package tetris;
  localparam int pos_w_lp = 8;

  typedef struct packed {
    logic [pos_w_lp-1:0] x;
    logic [pos_w_lp-1:0] y;
  } point_t;

  typedef enum logic [2:0] {eIDLE, eMerge, eScan, eShift, eDone} matrix_state_e;
endpackage

// File: rtl/matrix_window_read.sv
// Combinational 4x4 window of the board at (x_i, y_i); cells past the right wall or floor read as 1.
module matrix_window_read #(
  parameter int width_p  = 16,
  parameter int height_p = 32
) (
  input  logic [height_p-1:0][width_p-1:0] board_i,
  input  logic [$clog2(width_p):0]         x_i,
  input  logic [$clog2(height_p):0]        y_i,
  output logic [3:0][3:0]                  data_o
);
  localparam int xiw_lp = $clog2(width_p);
  localparam int yiw_lp = $clog2(height_p);
  localparam int xw_lp  = xiw_lp + 2;
  localparam int yw_lp  = yiw_lp + 2;

  always_comb begin
    logic [xw_lp-1:0] xc;
    logic [yw_lp-1:0] yr;
    data_o = '1;
    xc     = '0;
    yr     = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        // One extra bit keeps x+c from wrapping back onto the board.
        xc = {1'b0, x_i} + xw_lp'(c);
        yr = {1'b0, y_i} + yw_lp'(r);
        if (xc < xw_lp'(width_p) && yr < yw_lp'(height_p))
          data_o[r][c] = board_i[yr[yiw_lp-1:0]][xc[xiw_lp-1:0]];
      end
    end
  end
endmodule

// File: rtl/matrix_memory.sv
// Playfield board: zero-latency window read, tile lock merge and optional full-row removal.
// Row scanning/shifting only exists when TETRIS_LINE_CLEAR_EN is defined; otherwise a lock is merge then done.
module matrix_memory
  import tetris::*;
#(
  parameter int width_p  = 16,
  parameter int height_p = 32
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [$clog2(width_p):0]   mm_addr_r_x_i,
  input  logic [$clog2(height_p):0]  mm_addr_r_y_i,
  output logic [3:0][3:0]            mm_data_o,
  input  logic                       lock_v_i,
  output logic                       lock_ready_o,
  input  logic [3:0][3:0]            lock_shape_i,
  input  point_t                     lock_pos_i,
  input  logic                       clear_i,
  output logic                       done_o,
  output logic [$clog2(height_p):0]  lines_o
);
  localparam int xiw_lp = $clog2(width_p);
  localparam int yiw_lp = $clog2(height_p);
  localparam int tw_lp  = pos_w_lp + 1;

  matrix_state_e                    state_q, state_d;
  logic [height_p-1:0][width_p-1:0] board_q, board_d;
  logic [3:0][3:0]                  shape_q, shape_d;
  point_t                           pos_q, pos_d;
  logic [yiw_lp:0]                  cnt_q, cnt_d;
`ifdef TETRIS_LINE_CLEAR_EN
  logic [yiw_lp-1:0]                ptr_q, ptr_d;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= eIDLE;
      board_q <= '0;
      shape_q <= '0;
      pos_q   <= '0;
      cnt_q   <= '0;
`ifdef TETRIS_LINE_CLEAR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      shape_q <= shape_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
`ifdef TETRIS_LINE_CLEAR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  always_comb begin
    logic [tw_lp-1:0] tx;
    logic [tw_lp-1:0] ty;
    state_d = state_q;
    board_d = board_q;
    shape_d = shape_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    tx      = '0;
    ty      = '0;
`ifdef TETRIS_LINE_CLEAR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      eIDLE: begin
        if (clear_i) begin
          board_d = '0;
        end else if (lock_v_i) begin
          shape_d = lock_shape_i;
          pos_d   = lock_pos_i;
          cnt_d   = '0;
          state_d = eMerge;
        end
      end
      eMerge: begin
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) begin
            tx = {1'b0, pos_q.x} + tw_lp'(c);
            ty = {1'b0, pos_q.y} + tw_lp'(r);
            if (shape_q[r][c] && tx < tw_lp'(width_p) && ty < tw_lp'(height_p))
              board_d[ty[yiw_lp-1:0]][tx[xiw_lp-1:0]] = 1'b1;
          end
        end
`ifdef TETRIS_LINE_CLEAR_EN
        ptr_d   = yiw_lp'(height_p - 1);
        state_d = eScan;
`else
        state_d = eDone;
`endif
      end
`ifdef TETRIS_LINE_CLEAR_EN
      eScan: begin
        if (&board_q[ptr_q])
          state_d = eShift;
        else if (ptr_q == '0)
          state_d = eDone;
        else
          ptr_d = ptr_q - yiw_lp'(1);
      end
      eShift: begin
        // Pointer is held so the row that just dropped into it is rescanned.
        for (int i = 1; i < height_p; i++) begin
          if (yiw_lp'(i) <= ptr_q)
            board_d[i] = board_q[i-1];
        end
        board_d[0] = '0;
        cnt_d      = cnt_q + (yiw_lp+1)'(1);
        state_d    = eScan;
      end
`endif
      eDone:   state_d = eIDLE;
      default: state_d = eIDLE;
    endcase
  end

  assign lock_ready_o = (state_q == eIDLE);
  assign done_o       = (state_q == eDone);
  assign lines_o      = cnt_q;

  matrix_window_read #(
    .width_p  (width_p),
    .height_p (height_p)
  ) u_window (
    .board_i (board_q),
    .x_i     (mm_addr_r_x_i),
    .y_i     (mm_addr_r_y_i),
    .data_o  (mm_data_o)
  );
endmodule
